// File: rtl/sqrt_arb_pkg.sv
// Shared types and widths for the sqrt_arbiter block and its round-robin picker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sqrt_arb_pkg;

  // Argument and root widths of the shared sqrt unit
  localparam int XW = 32;
  localparam int RW = 16;

  // Sequencer states; 3-bit encoding keeps the register narrow
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DELIVER   = 3'd4
  } state_t;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Register width able to hold 0..n-1, never narrower than one bit
  function automatic int ptr_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/sqrt_arbiter_rr_pick.sv
// Round-robin winner selection: first asserted request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is consumed.
module rr_pick
  import sqrt_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]            req,
  input  logic [ptr_width(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]            gnt,
  output logic [ptr_width(NREQ)-1:0] idx
);

  localparam int PW = ptr_width(NREQ);

  // Scan ptr, ptr+1, ... modulo NREQ and stop at the first high request
  always_comb begin
    logic w_found;
    int   w_j;
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = int'(ptr) + k;
      if (w_j >= NREQ) begin
        w_j = w_j - NREQ;
      end
      if (!w_found && req[w_j]) begin
        w_found  = 1'b1;
        gnt[w_j] = 1'b1;
        idx      = PW'(w_j);
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one sqrt unit among NREQ requesters: round-robin grant, run pulse, busy handshake, done pulse.
// Latency: L+4 cycles from request seen in IDLE to IDLE again (done at L+3); watchdog abort at TMO+2.
// Backpressure: level requests are held until their own done; one transaction outstanding at a time.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TMO  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [XW*NREQ-1:0]   xin_bus,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic [RW-1:0]        result,
  output logic                 error,
  output logic                 sqrt_run,
  output logic [XW-1:0]        sqrt_xin,
  input  logic                 sqrt_busy,
  input  logic [RW-1:0]        sqrt_result
);

  localparam int PW = ptr_width(NREQ);
  localparam int CW = ptr_width(TMO);

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_win;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic [RW-1:0]   r_result;
  logic            r_error;
  logic            r_run;
  logic [XW-1:0]   r_xin;

  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_idx;
  logic [XW-1:0]   w_xin_sel;
  logic [PW-1:0]   w_ptr_next;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx)
  );

  // Argument of the candidate winner; only latched on the IDLE->LAUNCH edge
  always_comb begin
    w_xin_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_idx == PW'(k)) begin
        w_xin_sel = xin_bus[k*XW +: XW];
      end
    end
  end

  assign w_ptr_next = (r_win == PW'(NREQ - 1)) ? '0 : r_win + PW'(1);

  // Sequencer: grant, launch, watchdog, collect result, deliver.
  // r_error doubles as the abort flag: it is only ever set on the edge into DELIVER.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_win    <= '0;
      r_cnt    <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_error  <= 1'b0;
      r_run    <= 1'b0;
      r_xin    <= '0;
    end else begin
      r_run   <= 1'b0;
      r_done  <= '0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_win   <= w_idx;
            r_grant <= w_gnt;
            r_xin   <= w_xin_sel;
            r_run   <= 1'b1;
            r_state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (sqrt_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_cnt == CW'(TMO - 1)) begin
            r_result <= '0;
            r_done   <= r_grant;
            r_error  <= 1'b1;
            r_state  <= ST_DELIVER;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!sqrt_busy) begin
            r_result <= sqrt_result;
            r_done   <= r_grant;
            r_state  <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          r_grant <= '0;
          r_ptr   <= w_ptr_next;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant    = r_grant;
  assign done     = r_done;
  assign result   = r_result;
  assign error    = r_error;
  assign sqrt_run = r_run;
  assign sqrt_xin = r_xin;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a behavioural sqrt unit of fixed latency.
// Latency: sqrt model keeps busy high for LAT cycles after each accepted run.
// Backpressure: model can be made deaf to run to exercise the watchdog.
module tb_sqrt_arbiter;
  import sqrt_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int TMO  = 8;
  localparam int LAT  = 5;

  logic                clock;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [XW*NREQ-1:0]  xin_bus;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     done;
  logic [RW-1:0]       result;
  logic                error;
  logic                sqrt_run;
  logic [XW-1:0]       sqrt_xin;
  logic                sqrt_busy;
  logic [RW-1:0]       sqrt_result;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic        stub_dead = 1'b0;
  int          m_cnt;
  logic [15:0] m_res;

  int          bad_grant = 0;
  int          bad_owner = 0;
  int          bad_pulse = 0;
  int          run_cnt   = 0;
  int          done_cnt  = 0;
  logic [NREQ-1:0] prev_done = '0;

  sqrt_arbiter #(
    .NREQ (NREQ),
    .TMO  (TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .xin_bus     (xin_bus),
    .grant       (grant),
    .done        (done),
    .result      (result),
    .error       (error),
    .sqrt_run    (sqrt_run),
    .sqrt_xin    (sqrt_xin),
    .sqrt_busy   (sqrt_busy),
    .sqrt_result (sqrt_result)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    logic [31:0] tt;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t  = r | (16'd1 << b);
      tt = {16'd0, t} * {16'd0, t};
      if (tt <= x) r = t;
    end
    return r;
  endfunction

  // Behavioural sqrt unit: busy rises the cycle after run and stays high LAT cycles
  always @(posedge clock) begin
    if (reset) begin
      sqrt_busy   <= 1'b0;
      sqrt_result <= '0;
      m_cnt       <= 0;
      m_res       <= '0;
    end else if (sqrt_run && !stub_dead) begin
      sqrt_busy <= 1'b1;
      m_cnt     <= LAT;
      m_res     <= isqrt(sqrt_xin);
    end else if (sqrt_busy) begin
      if (m_cnt == 1) begin
        sqrt_busy   <= 1'b0;
        sqrt_result <= m_res;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // Protocol watch: grant one-hot, done only to owner, done one cycle wide
  always @(negedge clock) begin
    if (!$onehot0(grant)) bad_grant <= bad_grant + 1;
    if (|done && done != grant) bad_owner <= bad_owner + 1;
    if (|done && |(done & prev_done)) bad_pulse <= bad_pulse + 1;
    if (sqrt_run) run_cnt <= run_cnt + 1;
    if (|done) done_cnt <= done_cnt + 1;
    prev_done <= done;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_xin(input int i, input logic [31:0] v);
    xin_bus[i*XW +: XW] = v;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (done == '0 && n < 100);
    chk({tag, "_seen"}, 32'(|done), 32'd1);
  endtask

  task automatic do_single(input int i, input logic [31:0] x, input logic [15:0] er,
                           input logic ee, input int elat, input string tag);
    int t0;
    int r0;
    @(negedge clock);
    set_xin(i, x);
    req[i] = 1'b1;
    t0 = cyc;
    r0 = run_cnt;
    @(negedge clock);
    chk({tag, "_grant"}, 32'(grant), 32'd1 << i);
    chk({tag, "_run"}, 32'(sqrt_run), 32'd1);
    chk({tag, "_xin"}, sqrt_xin, x);
    wait_done(tag);
    chk({tag, "_lat"}, 32'(cyc - t0), 32'(elat));
    chk({tag, "_done"}, 32'(done), 32'd1 << i);
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_error"}, 32'(error), 32'(ee));
    req[i] = 1'b0;
    @(negedge clock);
    chk({tag, "_done_off"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(result), 32'(er));
    chk({tag, "_runs"}, 32'(run_cnt - r0), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_run"}, 32'(sqrt_run), 32'd0);
    chk({tag, "_xin"}, sqrt_xin, 32'd0);
  endtask

  logic [NREQ-1:0] exp_own [4];
  logic [15:0]     exp_res [4];

  initial begin
    int d0;
    reset   = 1'b1;
    req     = '0;
    xin_bus = '0;
    repeat (3) @(negedge clock);
    chk_all_zero("rst");
    reset = 1'b0;

    // Single request and argument extremes
    do_single(0, 32'd144, 16'd12, 1'b0, 3 + LAT, "sq144");
    do_single(0, 32'd0, 16'd0, 1'b0, 3 + LAT, "sq0");
    do_single(0, 32'hFFFF_FFFF, 16'd65535, 1'b0, 3 + LAT, "sqmax");
    do_single(0, 32'h4000_0000, 16'd32768, 1'b0, 3 + LAT, "sq2p30");

    // Watchdog: unit never acknowledges, then normal service resumes
    stub_dead = 1'b1;
    do_single(1, 32'h0000_1234, 16'd0, 1'b1, 2 + TMO, "wdog");
    stub_dead = 1'b0;
    do_single(1, 32'd49, 16'd7, 1'b0, 3 + LAT, "after_wdog");

    // Fairness: serving 2 moves ptr to 3, so 0 beats 2
    do_single(2, 32'd16, 16'd4, 1'b0, 3 + LAT, "solo2");
    @(negedge clock);
    set_xin(0, 32'd100);
    set_xin(2, 32'd400);
    req = 4'b0101;
    wait_done("fair_a");
    chk("fair_a_owner", 32'(done), 32'h1);
    chk("fair_a_result", 32'(result), 32'd10);
    req[0] = 1'b0;
    wait_done("fair_b");
    chk("fair_b_owner", 32'(done), 32'h4);
    chk("fair_b_result", 32'(result), 32'd20);
    req[2] = 1'b0;

    // Request dropped after grant and argument changed: still completes with old argument
    @(negedge clock);
    set_xin(3, 32'd10000);
    req[3] = 1'b1;
    @(negedge clock);
    chk("drop_grant", 32'(grant), 32'h8);
    req[3] = 1'b0;
    set_xin(3, 32'hFFFF_FFFF);
    wait_done("drop");
    chk("drop_owner", 32'(done), 32'h8);
    chk("drop_result", 32'(result), 32'd100);

    // Contention from reset: 0,1,3 then 0 again
    @(negedge clock);
    reset = 1'b1;
    set_xin(0, 32'd4);
    set_xin(1, 32'd9);
    set_xin(3, 32'd25);
    req = 4'b1011;
    @(negedge clock);
    reset = 1'b0;
    exp_own[0] = 4'b0001; exp_res[0] = 16'd2;
    exp_own[1] = 4'b0010; exp_res[1] = 16'd3;
    exp_own[2] = 4'b1000; exp_res[2] = 16'd5;
    exp_own[3] = 4'b0001; exp_res[3] = 16'd2;
    for (int k = 0; k < 4; k++) begin
      wait_done("cont");
      chk("cont_owner", 32'(done), 32'(exp_own[k]));
      chk("cont_result", 32'(result), 32'(exp_res[k]));
      if (k == 3) req = '0;
    end

    // Reset while the unit is busy: everything clears and no done follows
    @(negedge clock);
    set_xin(0, 32'd1000000);
    req = 4'b0001;
    repeat (4) @(negedge clock);
    chk("midrst_busy", 32'(sqrt_busy), 32'd1);
    reset = 1'b1;
    req   = '0;
    @(negedge clock);
    reset = 1'b0;
    chk_all_zero("midrst");
    d0 = done_cnt;
    repeat (15) @(negedge clock);
    chk("midrst_nodone", 32'(done_cnt - d0), 32'd0);
    do_single(0, 32'd81, 16'd9, 1'b0, 3 + LAT, "post_rst");

    chk("grant_onehot", 32'(bad_grant), 32'd0);
    chk("done_owner", 32'(bad_owner), 32'd0);
    chk("done_pulse", 32'(bad_pulse), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
